// File: rtl/soc_system_position_capture.sv
// Multi-channel Avalon-MM position capture port.
// Registers NUM_CH position words from the motion core and serves them as live reads.
// Software or an external trigger can take an atomic snapshot of all channels at once.
// Per-channel sticky change flags drive a maskable level interrupt.
module soc_system_position_capture #(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned DATA_W = 31,
   parameter int unsigned SIGNED = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [4:0]               address,
   input  logic                     read,
   input  logic                     write,
   input  logic [31:0]              writedata,
   output logic [31:0]              readdata,
   input  logic [NUM_CH*DATA_W-1:0] in_port,
   input  logic                     snap_trig,
   output logic                     irq
);

   // Word address of the last snapshot channel; reading it retires SNAP_VALID.
   localparam logic [4:0] SnapLastAddr = 5'(16 + NUM_CH - 1);

   // Widen one position word to 32 bits.
   function automatic logic [31:0] f_ext(input logic [DATA_W-1:0] x);
      logic [31:0] v;
      v = '0;
      v[DATA_W-1:0] = x;
      if (SIGNED != 0) begin
         for (int b = int'(DATA_W); b < 32; b++) begin
            v[b] = x[DATA_W-1];
         end
      end
      return v;
   endfunction

   logic [DATA_W-1:0] r_live_q  [NUM_CH];
   logic [DATA_W-1:0] r_live_qq [NUM_CH];
   logic [DATA_W-1:0] r_snap    [NUM_CH];

   logic              r_primed;
   logic              r_trig_q;
   logic              r_irq_en;
   logic              r_trig_en;
   logic              r_snap_valid;
   logic              r_overrun;
   logic [NUM_CH-1:0] r_flags;
   logic [NUM_CH-1:0] r_mask;
   logic [31:0]       r_snap_count;
   logic [31:0]       r_readdata;
   logic              r_irq;

   logic              w_wr_ctrl;
   logic              w_wr_status;
   logic              w_wr_change;
   logic              w_wr_mask;
   logic              w_sw_snap;
   logic              w_trig_snap;
   logic              w_capture;
   logic              w_clr_valid;
   logic              w_ovr_clr;
   logic [NUM_CH-1:0] w_change;
   logic [NUM_CH-1:0] w_flag_clr;
   logic [31:0]       w_rdata;
   logic              w_unused_wdata;

   assign w_wr_ctrl   = write && (address == 5'd0);
   assign w_wr_status = write && (address == 5'd1);
   assign w_wr_change = write && (address == 5'd2);
   assign w_wr_mask   = write && (address == 5'd3);

   // A software request and a trigger edge in the same cycle merge into one capture.
   assign w_sw_snap   = w_wr_ctrl && writedata[0];
   assign w_trig_snap = r_trig_en && snap_trig && !r_trig_q;
   assign w_capture   = w_sw_snap || w_trig_snap;

   assign w_clr_valid = read && (address == SnapLastAddr);
   assign w_ovr_clr   = w_wr_status && writedata[1];
   assign w_flag_clr  = w_wr_change ? writedata[NUM_CH-1:0] : '0;

   // Only a subset of the write bus is decoded, depending on NUM_CH.
   assign w_unused_wdata = ^writedata;

   assign readdata = r_readdata;
   assign irq      = r_irq;

   // Input pipeline: runs freely, validity after reset is tracked by r_primed.
   always_ff @(posedge clk) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
         r_live_q[i]  <= in_port[i*DATA_W +: DATA_W];
         r_live_qq[i] <= r_live_q[i];
      end
   end

   // Per-channel change detection between consecutive registered samples.
   always_comb begin
      w_change = '0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
         w_change[i] = r_primed && (r_live_q[i] != r_live_qq[i]);
      end
   end

   // Read data multiplexer for the addressed register.
   always_comb begin
      w_rdata = '0;
      if (address[4:3] == 2'b01) begin
         for (int i = 0; i < int'(NUM_CH); i++) begin
            if (address[2:0] == 3'(i)) begin
               w_rdata = f_ext(r_live_q[i]);
            end
         end
      end else if (address[4:3] == 2'b10) begin
         for (int i = 0; i < int'(NUM_CH); i++) begin
            if (address[2:0] == 3'(i)) begin
               w_rdata = f_ext(r_snap[i]);
            end
         end
      end else begin
         case (address)
            5'd0:    w_rdata = {29'd0, r_trig_en, r_irq_en, 1'b0};
            5'd1:    w_rdata = {30'd0, r_overrun, r_snap_valid};
            5'd2:    w_rdata = 32'(r_flags);
            5'd3:    w_rdata = 32'(r_mask);
            5'd4:    w_rdata = r_snap_count;
            default: w_rdata = '0;
         endcase
      end
   end

   // Bus-facing registers: read data, control, mask and interrupt output.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_readdata <= '0;
         r_irq_en   <= 1'b0;
         r_trig_en  <= 1'b0;
         r_mask     <= '0;
         r_irq      <= 1'b0;
         r_trig_q   <= 1'b0;
         r_primed   <= 1'b0;
      end else begin
         if (read) begin
            r_readdata <= w_rdata;
         end
         if (w_wr_ctrl) begin
            r_irq_en  <= writedata[1];
            r_trig_en <= writedata[2];
         end
         if (w_wr_mask) begin
            r_mask <= writedata[NUM_CH-1:0];
         end
         r_irq    <= r_irq_en && (|(r_flags & r_mask));
         r_trig_q <= snap_trig;
         r_primed <= 1'b1;
      end
   end

   // Sticky change flags; a new change outranks a simultaneous W1C.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_flags <= '0;
      end else begin
         r_flags <= (r_flags & ~w_flag_clr) | w_change;
      end
   end

   // Snapshot capture, counter and status bits.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_snap_valid <= 1'b0;
         r_overrun    <= 1'b0;
         r_snap_count <= '0;
         for (int i = 0; i < int'(NUM_CH); i++) begin
            r_snap[i] <= '0;
         end
      end else begin
         if (w_capture) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
               r_snap[i] <= r_live_q[i];
            end
            r_snap_count <= r_snap_count + 32'd1;
            r_snap_valid <= 1'b1;
         end else if (w_clr_valid) begin
            r_snap_valid <= 1'b0;
         end
         if (w_capture && r_snap_valid) begin
            r_overrun <= 1'b1;
         end else if (w_ovr_clr) begin
            r_overrun <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_soc_system_position_capture.sv
// Self-checking bench: directed vector table, hand-written corner sequences,
// then randomized traffic compared against a behavioural model.
module tb_soc_system_position_capture;

   localparam int NCH = 4;
   localparam int DW  = 31;

   logic           clk = 1'b0;
   logic           reset;
   logic [4:0]     address;
   logic           read;
   logic           write;
   logic [31:0]    writedata;
   logic [31:0]    readdata;
   logic [31:0]    readdata_u;
   logic [NCH*DW-1:0] in_port;
   logic           snap_trig;
   logic           irq;
   logic           irq_u;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   soc_system_position_capture #(.NUM_CH(NCH), .DATA_W(DW), .SIGNED(1)) u_dut (
      .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
      .writedata(writedata), .readdata(readdata), .in_port(in_port),
      .snap_trig(snap_trig), .irq(irq)
   );

   soc_system_position_capture #(.NUM_CH(NCH), .DATA_W(DW), .SIGNED(0)) u_dut_u (
      .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
      .writedata(writedata), .readdata(readdata_u), .in_port(in_port),
      .snap_trig(snap_trig), .irq(irq_u)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   logic [30:0] m_live [NCH];
   logic [30:0] m_prev [NCH];
   logic [30:0] m_snap [NCH];
   logic [31:0] m_count, m_rd;
   logic [3:0]  m_flags, m_mask;
   logic        m_irq_en, m_trig_en, m_valid, m_ovr, m_trig_q, m_primed, m_irq;
   logic        m_armed = 1'b0;

   // Two's-complement widening by arithmetic: bias, then subtract the bias.
   function automatic logic [31:0] ext_s(input logic [30:0] x);
      logic [31:0] v;
      v = {1'b0, x};
      return (v ^ 32'h4000_0000) - 32'h4000_0000;
   endfunction

   function automatic logic [31:0] reg_value(input int a);
      if (a == 0) return {29'd0, m_trig_en, m_irq_en, 1'b0};
      if (a == 1) return {30'd0, m_ovr, m_valid};
      if (a == 2) return {28'd0, m_flags};
      if (a == 3) return {28'd0, m_mask};
      if (a == 4) return m_count;
      if (a >= 8 && a < 8 + NCH) return ext_s(m_live[a-8]);
      if (a >= 16 && a < 16 + NCH) return ext_s(m_snap[a-16]);
      return 32'd0;
   endfunction

   always @(posedge clk) begin : model
      logic       cap, w1c, clr_valid, new_irq;
      logic [3:0] set, clr;
      logic [31:0] new_rd;
      if (reset) begin
         m_armed = 1'b1;
         m_rd = '0; m_irq = 0; m_irq_en = 0; m_trig_en = 0; m_mask = '0; m_flags = '0;
         m_count = '0; m_valid = 0; m_ovr = 0; m_trig_q = 0; m_primed = 0;
         for (int i = 0; i < NCH; i++) m_snap[i] = '0;
      end else begin
         cap = (write && address == 5'd0 && writedata[0]) ||
               (m_trig_en && snap_trig && !m_trig_q);
         new_rd = read ? reg_value(int'(address)) : m_rd;
         set = '0;
         for (int i = 0; i < NCH; i++) set[i] = m_primed && (m_live[i] != m_prev[i]);
         clr = (write && address == 5'd2) ? writedata[3:0] : 4'd0;
         new_irq = m_irq_en && ((m_flags & m_mask) != 4'd0);
         w1c = write && address == 5'd1 && writedata[1];
         clr_valid = read && (address == 5'(16 + NCH - 1));
         m_ovr = (m_ovr && !w1c) || (cap && m_valid);
         m_valid = cap || (m_valid && !clr_valid);
         if (cap) begin
            for (int i = 0; i < NCH; i++) m_snap[i] = m_live[i];
            m_count = m_count + 1;
         end
         m_flags = (m_flags & ~clr) | set;
         m_irq = new_irq;
         m_rd = new_rd;
         if (write && address == 5'd0) begin
            m_irq_en = writedata[1];
            m_trig_en = writedata[2];
         end
         if (write && address == 5'd3) m_mask = writedata[3:0];
         m_trig_q = snap_trig;
         m_primed = 1'b1;
      end
      for (int i = 0; i < NCH; i++) begin
         m_prev[i] = m_live[i];
         m_live[i] = in_port[i*DW +: DW];
      end
   end

   // Continuous comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (m_armed) begin
         check("model_readdata", readdata, m_rd);
         check("model_irq", {31'd0, irq}, {31'd0, m_irq});
      end
   end

   // ---------------- stimulus helpers (called just after a negedge) ----------------
   task automatic rd(input logic [4:0] a, output logic [31:0] v);
      read = 1'b1; address = a;
      @(negedge clk);
      read = 1'b0;
      v = readdata;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      write = 1'b1; address = a; writedata = d;
      @(negedge clk);
      write = 1'b0;
   endtask

   task automatic rd_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
      logic [31:0] v;
      rd(a, v);
      check(name, v, exp);
   endtask

   task automatic cycles(input int n);
      for (int k = 0; k < n; k++) @(negedge clk);
   endtask

   task automatic set_ch(input int ch, input logic [30:0] v);
      in_port[ch*DW +: DW] = v;
   endtask

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] exp_s;
      logic [31:0] exp_u;
   } vec_t;

   vec_t vecs[16];

   initial begin
      logic [31:0] v;
      logic [30:0] t;

      vecs[0]  = '{5'd0,  32'h0,         32'h0};
      vecs[1]  = '{5'd1,  32'h0,         32'h0};
      vecs[2]  = '{5'd2,  32'h0,         32'h0};
      vecs[3]  = '{5'd3,  32'h0,         32'h0};
      vecs[4]  = '{5'd4,  32'h0,         32'h0};
      vecs[5]  = '{5'd5,  32'h0,         32'h0};
      vecs[6]  = '{5'd12, 32'h0,         32'h0};
      vecs[7]  = '{5'd16, 32'h0,         32'h0};
      vecs[8]  = '{5'd17, 32'h0,         32'h0};
      vecs[9]  = '{5'd19, 32'h0,         32'h0};
      vecs[10] = '{5'd31, 32'h0,         32'h0};
      vecs[11] = '{5'd9,  32'h3FFF_FFFF, 32'h3FFF_FFFF};
      vecs[12] = '{5'd10, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
      vecs[13] = '{5'd11, 32'h0000_0005, 32'h0000_0005};
      vecs[14] = '{5'd20, 32'h0,         32'h0};
      vecs[15] = '{5'd8,  32'hC000_0000, 32'h4000_0000};

      reset = 1'b1; read = 0; write = 0; address = '0; writedata = '0; snap_trig = 0;
      in_port = '0;
      set_ch(0, 31'h4000_0000); set_ch(1, 31'h3FFF_FFFF);
      set_ch(2, 31'h7FFF_FFFF); set_ch(3, 31'h0000_0005);
      cycles(3);
      reset = 1'b0;
      check("reset_irq", {31'd0, irq}, 32'd0);
      check("reset_irq_u", {31'd0, irq_u}, 32'd0);

      // Reset values and extension, one-cycle read latency.
      for (int i = 0; i < 16; i++) begin
         rd(vecs[i].addr, v);
         check($sformatf("vec%0d_a%0d_s", i, vecs[i].addr), v, vecs[i].exp_s);
         check($sformatf("vec%0d_a%0d_u", i, vecs[i].addr), readdata_u, vecs[i].exp_u);
      end
      address = 5'd0;
      @(negedge clk);
      check("readdata_hold", readdata, 32'hC000_0000);

      // Software snapshot.
      set_ch(0, 31'd1); set_ch(1, 31'd2); set_ch(2, 31'd3); set_ch(3, 31'd4);
      cycles(2);
      wr(5'd0, 32'h1);
      for (int i = 0; i < NCH; i++) set_ch(i, 31'd9);
      rd_chk("sw_status_pre", 5'd1, 32'h1);
      rd_chk("sw_snap0", 5'd16, 32'd1);
      rd_chk("sw_snap1", 5'd17, 32'd2);
      rd_chk("sw_snap2", 5'd18, 32'd3);
      rd_chk("sw_status_mid", 5'd1, 32'h1);
      rd_chk("sw_snap3", 5'd19, 32'd4);
      rd_chk("sw_status_post", 5'd1, 32'h0);
      rd_chk("sw_count", 5'd4, 32'd1);
      rd_chk("ctrl_snap_reads0", 5'd0, 32'd0);

      // Trigger edge, overrun, W1C, coincident request.
      wr(5'd0, 32'h4);
      snap_trig = 1'b1; cycles(3); snap_trig = 1'b0; cycles(1);
      rd_chk("trig_count", 5'd4, 32'd2);
      rd_chk("trig_status", 5'd1, 32'h1);
      snap_trig = 1'b1; cycles(2); snap_trig = 1'b0; cycles(1);
      rd_chk("ovr_status", 5'd1, 32'h3);
      rd_chk("ovr_count", 5'd4, 32'd3);
      wr(5'd1, 32'h2);
      rd_chk("w1c_status", 5'd1, 32'h1);
      snap_trig = 1'b1; write = 1'b1; address = 5'd0; writedata = 32'h5;
      @(negedge clk);
      write = 1'b0; snap_trig = 1'b0;
      cycles(1);
      rd_chk("coincident_count", 5'd4, 32'd4);
      wr(5'd0, 32'h0);
      snap_trig = 1'b1; cycles(2); snap_trig = 1'b0; cycles(1);
      rd_chk("trig_disabled_count", 5'd4, 32'd4);

      // Interrupt and change flags.
      wr(5'd2, 32'hF);
      wr(5'd3, 32'h2);
      wr(5'd0, 32'h2);
      cycles(2);
      check("irq_idle", {31'd0, irq}, 32'd0);
      set_ch(0, 31'd100);
      cycles(4);
      rd_chk("change_ch0", 5'd2, 32'h1);
      check("irq_masked", {31'd0, irq}, 32'd0);
      set_ch(1, 31'd200);
      cycles(3);
      check("irq_ch1", {31'd0, irq}, 32'd1);
      t = 31'd200;
      for (int k = 0; k < 6; k++) begin
         t = t ^ 31'd1;
         set_ch(1, t);
         write = (k == 3); address = 5'd2; writedata = 32'h2;
         @(negedge clk);
      end
      write = 1'b0;
      cycles(3);
      rd_chk("change_set_wins", 5'd2, 32'h3);
      check("irq_held", {31'd0, irq}, 32'd1);
      wr(5'd2, 32'h2);
      cycles(2);
      rd_chk("change_cleared", 5'd2, 32'h1);
      check("irq_dropped", {31'd0, irq}, 32'd0);

      // Reset coincident with a capture request.
      reset = 1'b1; write = 1'b1; address = 5'd0; writedata = 32'h1;
      @(negedge clk);
      reset = 1'b0; write = 1'b0;
      rd_chk("rst_cap_count", 5'd4, 32'd0);
      rd_chk("rst_cap_status", 5'd1, 32'd0);
      rd_chk("rst_cap_snap0", 5'd16, 32'd0);
      rd_chk("rst_cap_ctrl", 5'd0, 32'd0);

      // Counter wrap from a preset value.
      force u_dut.r_snap_count = 32'hFFFF_FFFF;
      m_count = 32'hFFFF_FFFF;
      @(negedge clk);
      release u_dut.r_snap_count;
      rd_chk("wrap_pre", 5'd4, 32'hFFFF_FFFF);
      wr(5'd0, 32'h1);
      rd_chk("wrap_post", 5'd4, 32'h0);

      // Randomized traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         reset     = ($urandom_range(0, 149) == 0);
         read      = $urandom_range(0, 1) == 1;
         write     = ($urandom_range(0, 3) == 0);
         address   = 5'($urandom_range(0, 31));
         writedata = $urandom;
         if ($urandom_range(0, 3) == 0) snap_trig = ~snap_trig;
         if ($urandom_range(0, 7) == 0) set_ch(int'($urandom_range(0, NCH - 1)), 31'($urandom));
         @(negedge clk);
      end
      reset = 1'b0; read = 1'b0; write = 1'b0;
      cycles(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
